// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode encodings and
// the counter-width helper.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_RSV  = 3'b111;

    // Bits needed to hold the values 0..width inclusive.
    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_shift_cnt.sv
// Modulo-WIDTH shift counter with a registered one-cycle done pulse on
// completion of a full word of shifts.
module usr_shift_cnt
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = calc_cw(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          restart,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          done_r;

    // Count state and done pulse; restart has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (restart) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (inc) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r  <= '0;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + ONE_CNT;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign cnt  = cnt_r;
    assign done = done_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: load, shift, rotate and clear with serial taps at
// both ends and a word-completion counter.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CW      = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             inc_s;
    logic             restart_s;

    // Next-value mux and counter control decoded from the mode.
    always_comb begin
        q_next_s  = q_r;
        inc_s     = 1'b0;
        restart_s = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: q_next_s = q_r;
                MODE_LOAD: begin
                    q_next_s  = d;
                    restart_s = 1'b1;
                end
                MODE_SHL: begin
                    q_next_s = {q_r[WIDTH-2:0], sin_r};
                    inc_s    = 1'b1;
                end
                MODE_SHR: begin
                    q_next_s = {sin_l, q_r[WIDTH-1:1]};
                    inc_s    = 1'b1;
                end
                MODE_ROL: begin
                    q_next_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    inc_s    = 1'b1;
                end
                MODE_ROR: begin
                    q_next_s = {q_r[0], q_r[WIDTH-1:1]};
                    inc_s    = 1'b1;
                end
                MODE_CLR: begin
                    q_next_s  = RST_VAL;
                    restart_s = 1'b1;
                end
                MODE_RSV: q_next_s = q_r;
                default:  q_next_s = q_r;
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // Data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= q_next_s;
        end
    end

    usr_shift_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc_s),
        .restart (restart_s),
        .cnt     (cnt),
        .done    (done)
    );

    assign q      = q_r;
    assign sout_l = q_r[WIDTH-1];
    assign sout_r = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8, RST_VAL=8'hA5.
module tb_univ_shift_reg;

    localparam int         W   = 8;
    localparam logic [2:0] HLD = 3'b000;
    localparam logic [2:0] LD  = 3'b001;
    localparam logic [2:0] SL  = 3'b010;
    localparam logic [2:0] SR  = 3'b011;
    localparam logic [2:0] RL  = 3'b100;
    localparam logic [2:0] RR  = 3'b101;
    localparam logic [2:0] CL  = 3'b110;
    localparam logic [2:0] RV  = 3'b111;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] d = 8'h00;
    logic         sin_l = 1'b0;
    logic         sin_r = 1'b0;
    logic [W-1:0] q;
    logic         sout_l;
    logic         sout_r;
    logic [3:0]   cnt;
    logic         done;

    int total = 0;
    int bad = 0;

    univ_shift_reg #(.WIDTH(W), .RST_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
        .sout_r(sout_r), .cnt(cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dv,
                        input logic sl, input logic sr);
        en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq,
                             input logic [3:0] ec, input logic ed);
        chk({tag, "_q"}, {24'h0, q}, {24'h0, eq});
        chk({tag, "_cnt"}, {28'h0, cnt}, {28'h0, ec});
        chk({tag, "_done"}, {31'h0, done}, {31'h0, ed});
    endtask

    initial begin
        logic [7:0] sr_exp;
        sr_exp = 8'b1000_0001;

        // Reset overrides an enabled load.
        rst = 1'b1;
        step(1'b1, LD, 8'hFF, 1'b0, 1'b0);
        rst = 1'b0;
        chk_state("reset", 8'hA5, 4'd0, 1'b0);
        chk("reset_soutl", {31'h0, sout_l}, 32'h1);

        // Load then shift right a full word.
        step(1'b1, LD, 8'h81, 1'b0, 1'b0);
        chk_state("load81", 8'h81, 4'd0, 1'b0);
        chk("load81_soutl", {31'h0, sout_l}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("shr_sout_r%0d", i), {31'h0, sout_r}, {31'h0, sr_exp[i]});
            step(1'b1, SR, 8'h00, 1'b0, 1'b0);
            if (i == 6) chk_state("shr7", 8'h01, 4'd7, 1'b0);
        end
        chk_state("shr8", 8'h00, 4'd0, 1'b1);
        step(1'b1, HLD, 8'h00, 1'b0, 1'b0);
        chk_state("shr_after", 8'h00, 4'd0, 1'b0);

        // Rotations in both directions share one count.
        step(1'b1, LD, 8'h96, 1'b0, 1'b0);
        step(1'b1, RL, 8'h00, 1'b0, 1'b0);
        chk("rol1_q", {24'h0, q}, 32'h2D);
        step(1'b1, RL, 8'h00, 1'b0, 1'b0);
        step(1'b1, RL, 8'h00, 1'b0, 1'b0);
        chk_state("rol3", 8'hB4, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, RR, 8'h00, 1'b0, 1'b0);
        chk_state("ror3", 8'h96, 4'd6, 1'b0);
        step(1'b1, RL, 8'h00, 1'b0, 1'b0);
        chk_state("rol_7th", 8'h2D, 4'd7, 1'b0);
        step(1'b1, RL, 8'h00, 1'b0, 1'b0);
        chk_state("rol_8th", 8'h5A, 4'd0, 1'b1);

        // Enable gating: only enabled edges shift; disabled edge clears done.
        step(1'b0, LD, 8'h00, 1'b0, 1'b0);
        chk_state("en0_hold", 8'h5A, 4'd0, 1'b0);
        step(1'b1, LD, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step((i % 2) == 0, SL, 8'h00, 1'b0, 1'b1);
            if (i == 1) chk_state("en_toggle2", 8'h01, 4'd1, 1'b0);
        end
        chk_state("en_toggle", 8'h0F, 4'd4, 1'b0);

        // Seven shifts then clear: no done pulse.
        step(1'b1, LD, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, SR, 8'h00, 1'b1, 1'b0);
        chk_state("shr7_ones", 8'hFE, 4'd7, 1'b0);
        step(1'b1, CL, 8'h00, 1'b0, 1'b0);
        chk_state("clear", 8'hA5, 4'd0, 1'b0);
        step(1'b1, SL, 8'h00, 1'b0, 1'b1);
        step(1'b1, SL, 8'h00, 1'b0, 1'b1);
        chk_state("shl2", 8'h97, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, RV, 8'hFF, 1'b1, 1'b1);
        chk_state("reserved", 8'h97, 4'd2, 1'b0);

        // Load at cnt=WIDTH-1 restarts without a pulse.
        for (int i = 0; i < 5; i++) step(1'b1, SL, 8'h00, 1'b0, 1'b0);
        chk("pre_load_cnt", {28'h0, cnt}, 32'd7);
        step(1'b1, LD, 8'h3C, 1'b0, 1'b0);
        chk_state("load_at7", 8'h3C, 4'd0, 1'b0);

        // Reset aborts a shift sequence.
        step(1'b1, LD, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, SL, 8'h00, 1'b0, 1'b1);
        chk_state("shl5", 8'h1F, 4'd5, 1'b0);
        rst = 1'b1;
        step(1'b1, SL, 8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        chk_state("mid_reset", 8'hA5, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, SR, 8'h00, 1'b0, 1'b0);
            if (i == 6) chk("rerun7_done", {31'h0, done}, 32'h0);
        end
        chk_state("rerun8", 8'h00, 4'd0, 1'b1);
        step(1'b1, HLD, 8'h00, 1'b0, 1'b0);
        chk("rerun_after_done", {31'h0, done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register. It generalises the single enabled D flip-flop to a WIDTH-bit register with load, shift, rotate and clear modes, serial in/out at both ends, and a shift counter that flags completion of a full word of serial traffic. It is the common storage and serialiser element for lab datapaths and serial links: load a word, shift it out, shift a word in, then read it in parallel.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32.
RST_VAL, 0, value loaded into q on reset and in CLEAR mode; WIDTH bits.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous reset, active-high.
en  input  1  clock enable; 0 = hold all state.
mode  input  3  operation select; encodings under Behaviour.
d  input  WIDTH  parallel load data.
sin_l  input  1  serial input entering the MSB on a right shift.
sin_r  input  1  serial input entering the LSB on a left shift.
q  output  WIDTH  register contents.
sout_l  output  1  equals q[WIDTH-1]; combinational from q.
sout_r  output  1  equals q[0]; combinational from q.
cnt  output  CW  shift/rotate count since the last load or clear; CW = clog2(WIDTH+1).
done  output  1  one-cycle pulse when cnt completes WIDTH shifts.

Behaviour:
- One clock domain. Reset is synchronous and active-high (clk, rst). All state updates on the rising edge of clk.
- Priority order: rst, then en, then mode.
- Reset (rst=1 at an edge): q <= RST_VAL, cnt <= 0, done <= 0. mode and en are ignored. A reset in the middle of a shift sequence aborts it, and no done pulse is produced.
- en=0: q and cnt hold; done <= 0.
- en=1, mode encodings:
  - 000 HOLD: q <= q.
  - 001 LOAD: q <= d; cnt <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_r}.
  - 011 SHR: q <= {sin_l, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 CLEAR: q <= RST_VAL; cnt <= 0.
  - 111 reserved; behaves exactly as HOLD.
- Counter:
  - Increments by 1 on every enabled SHL, SHR, ROL or ROR.
  - If the increment would reach WIDTH, cnt <= 0 and done <= 1 on that same edge. done is registered, so it is high in the cycle after the WIDTH-th shift edge, together with the updated q.
  - done is 0 in every other cycle. Back-to-back words give one done pulse every WIDTH enabled shifts.
  - HOLD and reserved do not change cnt.
  - LOAD or CLEAR restarts counting from 0 with no done pulse, even if cnt = WIDTH-1.
- Latency: q, cnt and done reflect a command one cycle after the edge that samples it. sout_l and sout_r follow q with zero added latency.
- Mixing directions (for example SHL then SHR) still counts each operation; the counter does not track direction.
- Only the low CW bits of the count are stored. No arithmetic overflow is possible because cnt never exceeds WIDTH-1.

Decomposition:
- Package usr_pkg:
  - mode localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CLR, MODE_RSV;
  - a clog2-based constant function for CW.
- One natural sub-module: usr_shift_cnt. It contains the modulo-WIDTH counter and the done register, with inputs clk, rst, inc and restart.
- The top level holds the data-register mux and instantiates usr_shift_cnt.

Test Plan:
- WIDTH=8, RST_VAL=8'hA5. Assert rst with en=1, mode=LOAD, d=8'hFF -> q=8'hA5, cnt=0, done=0. Load is ignored.
- LOAD d=8'h81, then 8 enabled SHR with sin_l=0 -> sout_r sequence is 1,0,0,0,0,0,0,1 (sampled before each edge); q=8'h00 afterwards; done high for exactly one cycle after the 8th edge; cnt=0.
- LOAD 8'h96, then ROL x3 -> q=8'hB4, cnt=3. Then ROR x3 -> q=8'h96, cnt=6. Then 2 more ROL -> q=8'h5A, done pulse, cnt=0.
- LOAD 8'h00, SHL x4 with sin_r=1 and en toggling 1,0,1,0,... -> only enabled edges shift; q=8'h0F after the 4th enabled edge; cnt=4; done=0.
- Shift 7 times, then CLEAR -> q=RST_VAL, cnt=0, no done. Then mode=111 for 3 cycles -> q and cnt unchanged.
- Shift 5 times, then assert rst in the next cycle with mode=SHL -> q=RST_VAL, cnt=0, done stays 0. Re-run 8 shifts -> done pulses once.
